// File: rtl/arith_accumulator_ctrl.sv
// Valid/ready sequencer with a running accumulator for a combinational 4-bit add/sub unit.
// Define ACC_SAT_EN to saturate acc on carry/borrow instead of wrapping.
module arith_accumulator_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   output logic             au_sel,
   input  logic [WIDTH-1:0] au_result,
   input  logic             au_carry,
   input  logic             au_overflow,
   output logic [WIDTH-1:0] acc,
   output logic             out_valid,
   output logic             carry_flag,
   output logic             ovf_flag
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_t           state;
   state_t           next_state;
   logic [1:0]       op_r;
   logic             accept;
   logic [WIDTH-1:0] arith_value;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // in_ready and out_valid are masked by rst so a reset cycle never handshakes.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            accept   = in_valid & ~rst;
            if (accept) begin
               next_state = EXEC;
            end
         end
         EXEC: begin
            next_state = DONE;
         end
         DONE: begin
            out_valid  = ~rst;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

`ifdef ACC_SAT_EN
   always_comb begin
      arith_value = au_result;
      if (au_carry) begin
         arith_value = (op_r == OP_ADD) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      end
   end
`else
   always_comb begin
      arith_value = au_result;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         op_r       <= OP_LOAD;
         au_b       <= '0;
         au_sel     <= 1'b0;
         acc        <= '0;
         carry_flag <= 1'b0;
         ovf_flag   <= 1'b0;
      end else begin
         if (accept) begin
            op_r   <= in_op;
            au_b   <= (in_op == OP_CLEAR) ? '0 : in_data;
            au_sel <= (in_op == OP_SUB);
         end
         if (state == EXEC) begin
            case (op_r)
               OP_LOAD: begin
                  acc <= au_b;
               end
               OP_ADD, OP_SUB: begin
                  acc        <= arith_value;
                  carry_flag <= carry_flag | au_carry;
                  ovf_flag   <= ovf_flag | au_overflow;
               end
               default: begin
                  acc        <= '0;
                  carry_flag <= 1'b0;
                  ovf_flag   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign au_a = acc;

endmodule
